// File: rtl/sta_pipe_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sta_pipe_if : valid/ready bus, flush and occupancy of sta_pipe   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface sta_pipe_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    occupancy;

   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, occupancy
   );

   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, occupancy
   );
endinterface
`default_nettype wire

// File: rtl/sta_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sta_pipe : DEPTH-stage elastic register pipeline with flush      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sta_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   sta_pipe_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]            v_q;
   logic [DEPTH-1:0]            v_d;
   logic [DEPTH-1:0][WIDTH-1:0] d_q;
   logic [DEPTH-1:0][WIDTH-1:0] d_d;

   logic [DEPTH-1:0]            w_rdy;
   logic [DEPTH-1:0]            w_up_v;
   logic [DEPTH-1:0][WIDTH-1:0] w_up_d;
   logic                        w_in_ready;
   logic [CW-1:0]               w_occ;

   // Ready ripples combinationally from out_ready back to stage 0 on purpose:
   // this path is the timing target being swept, so no skid buffer breaks it.
   always_comb begin : p_ready
      logic [DEPTH-1:0] rdy;
      rdy            = '0;
      rdy[DEPTH-1]   = !v_q[DEPTH-1] || bus.out_ready;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         rdy[i] = !v_q[i] || rdy[i+1];
      end
      w_rdy = rdy;
   end

   assign w_in_ready = w_rdy[0] && !bus.flush;

   always_comb begin : p_upstream
      w_up_v    = '0;
      w_up_d    = '0;
      w_up_v[0] = bus.in_valid && w_in_ready;
      w_up_d[0] = bus.in_data;
      for (int i = 1; i < DEPTH; i++) begin
         w_up_v[i] = v_q[i-1];
         w_up_d[i] = d_q[i-1];
      end
   end

   // Payload only moves with a valid beat, so empty stages keep old data.
   always_comb begin : p_next
      v_d = v_q;
      d_d = d_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_rdy[i]) begin
            v_d[i] = w_up_v[i];
            if (w_up_v[i]) begin
               d_d[i] = w_up_d[i];
            end
         end
      end
      if (bus.flush) begin
         v_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         d_q <= '0;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   always_comb begin : p_occupancy
      logic [CW-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt = cnt + CW'(v_q[i]);
      end
      w_occ = cnt;
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = v_q[DEPTH-1];
   assign bus.out_data  = d_q[DEPTH-1];
   assign bus.occupancy = w_occ;
endmodule
`default_nettype wire

// File: tb/tb_sta_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sta_pipe : directed and randomised bench for sta_pipe         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_sta_pipe;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Directed instance, WIDTH = 8, DEPTH = 3
   sta_pipe_if #(.WIDTH(8), .DEPTH(3)) bus ();
   sta_pipe #(.WIDTH(8), .DEPTH(3)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // One cycle: drive inputs, check at the falling edge, step past the rising edge.
   task automatic vec(input string tag, input int iv, input int id, input int ordy, input int fl,
                      input int e_ir, input int e_ov, input int e_od, input int e_occ);
      bus.in_valid  = iv[0];
      bus.in_data   = id[7:0];
      bus.out_ready = ordy[0];
      bus.flush     = fl[0];
      @(negedge clk);
      chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(e_ir));
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(e_ov));
      chk({tag, "_occupancy"}, 32'(bus.occupancy), 32'(e_occ));
      if (e_ov != 0) chk({tag, "_out_data"}, 32'(bus.out_data), 32'(e_od));
      @(posedge clk);
      #1;
   endtask

   // Randomised instances for DEPTH 1, 2 and 5 share one stimulus stream
   logic       rnd_rst   = 1'b1;
   logic       rnd_valid = 1'b0;
   logic       rnd_ready = 1'b0;
   logic       rnd_flush = 1'b0;
   logic [7:0] rnd_data  = 8'h00;

   for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
      localparam int D = (gi == 0) ? 1 : ((gi == 1) ? 2 : 5);

      sta_pipe_if #(.WIDTH(8), .DEPTH(D)) rif ();
      sta_pipe #(.WIDTH(8), .DEPTH(D)) u_dut (
         .clk (clk),
         .rst (rnd_rst),
         .bus (rif.slave)
      );

      assign rif.in_valid  = rnd_valid;
      assign rif.in_data   = rnd_data;
      assign rif.out_ready = rnd_ready;
      assign rif.flush     = rnd_flush;

      logic [7:0] sb[$];
      logic [7:0] exp_b;

      always @(negedge clk) begin
         if (rnd_rst) begin
            sb.delete();
         end else begin
            chk($sformatf("rnd_d%0d_occupancy", D), 32'(rif.occupancy), 32'(sb.size()));
            if (rnd_flush) chk($sformatf("rnd_d%0d_flush_in_ready", D), 32'(rif.in_ready), 32'd0);
            if (rif.out_valid && rif.out_ready) begin
               chk($sformatf("rnd_d%0d_emit_nonempty", D), 32'(sb.size() > 0), 32'd1);
               if (sb.size() > 0) begin
                  exp_b = sb.pop_front();
                  chk($sformatf("rnd_d%0d_out_data", D), 32'(rif.out_data), 32'(exp_b));
               end
            end
            if (rnd_flush) sb.delete();
            else if (rif.in_valid && rif.in_ready) sb.push_back(rif.in_data);
         end
      end
   end

   initial begin
      // Reset for two edges with a beat offered
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h55;
      bus.out_ready = 1'b0;
      bus.flush     = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'h00);
      chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
      bus.out_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         chk("rst_no_ghost", 32'(bus.out_valid), 32'd0);
         @(posedge clk);
         #1;
      end

      // Streaming 0x01..0x10, first output three cycles after presentation
      bus.out_ready = 1'b1;
      for (int t = 0; t < 20; t++) begin
         bus.in_valid = (t < 16);
         bus.in_data  = 8'(t + 1);
         @(negedge clk);
         if (t < 16) chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
         chk("stream_out_valid", 32'(bus.out_valid), 32'(t >= 3 && t < 19));
         if (t >= 3 && t < 19) chk("stream_out_data", 32'(bus.out_data), 32'(t - 2));
         @(posedge clk);
         #1;
      end

      // Backpressure: three accepted, fourth waits until out_ready rises
      //     tag    iv id     ordy fl ir ov od     occ
      vec("bp0", 1, 'h21, 0, 0, 1, 0, 'h00, 0);
      vec("bp1", 1, 'h22, 0, 0, 1, 0, 'h00, 1);
      vec("bp2", 1, 'h23, 0, 0, 1, 0, 'h00, 2);
      vec("bp3", 1, 'h24, 0, 0, 0, 1, 'h21, 3);
      vec("bp4", 1, 'h24, 0, 0, 0, 1, 'h21, 3);
      vec("bp5", 1, 'h24, 1, 0, 1, 1, 'h21, 3);
      vec("bp6", 0, 'h00, 1, 0, 1, 1, 'h22, 3);
      vec("bp7", 0, 'h00, 1, 0, 1, 1, 'h23, 2);
      vec("bp8", 0, 'h00, 1, 0, 1, 1, 'h24, 1);
      vec("bp9", 0, 'h00, 1, 0, 1, 0, 'h00, 0);

      // Bubble collapse: A0, idle, A1 packed behind a stalled output
      vec("bub0", 1, 'hA0, 0, 0, 1, 0, 'h00, 0);
      vec("bub1", 0, 'h00, 0, 0, 1, 0, 'h00, 1);
      vec("bub2", 1, 'hA1, 0, 0, 1, 0, 'h00, 1);
      vec("bub3", 0, 'h00, 0, 0, 1, 1, 'hA0, 2);
      vec("bub4", 0, 'h00, 0, 0, 1, 1, 'hA0, 2);
      vec("bub5", 0, 'h00, 1, 0, 1, 1, 'hA0, 2);
      vec("bub6", 0, 'h00, 1, 0, 1, 1, 'hA1, 1);
      vec("bub7", 0, 'h00, 1, 0, 1, 0, 'h00, 0);

      // Flush a full pipe, then a fresh beat emerges three cycles later
      vec("fl0", 1, 'h31, 0, 0, 1, 0, 'h00, 0);
      vec("fl1", 1, 'h32, 0, 0, 1, 0, 'h00, 1);
      vec("fl2", 1, 'h33, 0, 0, 1, 0, 'h00, 2);
      vec("fl3", 1, 'h34, 0, 1, 0, 1, 'h31, 3);
      vec("fl4", 1, 'h35, 1, 0, 1, 0, 'h00, 0);
      vec("fl5", 0, 'h00, 1, 0, 1, 0, 'h00, 1);
      vec("fl6", 0, 'h00, 1, 0, 1, 0, 'h00, 1);
      vec("fl7", 0, 'h00, 1, 0, 1, 1, 'h35, 1);
      vec("fl8", 0, 'h00, 1, 0, 1, 0, 'h00, 0);

      // Randomised valid/ready/flush on DEPTH 1, 2, 5
      repeat (2) @(posedge clk);
      #1;
      rnd_rst = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         rnd_valid = ($urandom_range(0, 9) < 7);
         rnd_ready = ($urandom_range(0, 9) < 6);
         rnd_flush = ($urandom_range(0, 49) == 0);
         rnd_data  = 8'($urandom);
         @(posedge clk);
         #1;
      end
      rnd_valid = 1'b0;
      rnd_flush = 1'b0;
      rnd_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/sta_pipe.md
# sta_pipe

Parametrised elastic register pipeline: the successor to our fixed two-flop launch/capture path. It carries a WIDTH-bit payload through DEPTH register stages with a valid/ready handshake, a synchronous flush and an occupancy count. It sits between any producer/consumer pair where we need registered, timing-closable stage boundaries whose count can be swept for STA experiments without changing the surrounding logic.

## Interface
- WIDTH, 8, payload width in bits (≥1)
- DEPTH, 2, number of register stages (≥1)
- CW, $clog2(DEPTH+1), occupancy width (derived, not overridden)

- clk  in  1  single clock, all flops on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of all in-flight beats
- in_valid  in  1  producer has a beat on in_data
- in_ready  out  1  pipeline accepts a beat this cycle
- in_data  in  WIDTH  producer payload
- out_valid  out  1  last stage holds a beat
- out_ready  in  1  consumer accepts the beat this cycle
- out_data  out  WIDTH  last-stage payload
- occupancy  out  CW  number of valid stages, 0..DEPTH

## Operation
- Stage i (0 = input side, DEPTH-1 = output side) holds v[i] and d[i].
- Stage readiness is combinational:
  - r[DEPTH-1] = !v[DEPTH-1] || out_ready
  - r[i] = !v[i] || r[i+1]
- in_ready = r[0] && !flush.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Per-stage update on each clk edge, when not in reset or flush:
  - If r[i]: v[i] <= v[i-1] (stage 0 takes in_valid && in_ready) and d[i] <= d[i-1] (stage 0 takes in_data).
  - Otherwise the stage holds.
- d[i] loads only when the incoming valid is 1; otherwise d[i] keeps its old value (power and STA consistency).
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
- occupancy = popcount(v), combinational from the registers.
- flush = 1: all v[i] <= 0 on the next edge, and no input is accepted that cycle. d[i] is unchanged. An output transfer may still be signalled in the flush cycle. The consumer counts it, and the beat is then gone.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except by flush.
- Bubbles collapse: an empty stage always accepts from upstream, even while downstream is stalled.
- DEPTH = 1 degenerates to a single-entry register slice, with in_ready = !v[0] || out_ready.

## Timing
- Reset (rst = 1 at an edge): all v[i] = 0 and all d[i] = 0. Outputs after that edge: out_valid = 0, out_data = 0, occupancy = 0.
- During reset: in_ready = r[0] && !flush, which evaluates to 1 unless flush is high.
- rst has priority over flush and over all transfers.
- A beat accepted while rst is high is discarded.
- Latency: a beat accepted at edge k into an empty pipe with out_ready held 1 appears with out_valid = 1 after edge k+DEPTH-1, i.e. DEPTH cycles from presentation to out_valid.
- Throughput: 1 beat/cycle sustained when out_ready = 1, including when full.
- Full (occupancy = DEPTH) with out_ready = 0:
  - in_ready = 0 in the same cycle; everything holds.
  - out_data is stable while out_valid && !out_ready.
- Full with out_ready = 1: in_ready = 1. A simultaneous in/out transfer shifts every stage and occupancy stays DEPTH.
- Empty with in_valid = 1: in_ready = 1; occupancy becomes 1 after the edge.
- The ready path is combinational from out_ready to in_ready across all DEPTH stages. This is a deliberate STA target; no skid buffer is inserted.
- Reset or flush asserted mid-stream: after that single edge, occupancy = 0 and out_valid = 0. Normal operation resumes on the following cycle.

## Test plan
- Reset with WIDTH = 8, DEPTH = 3:
  - Assert rst for 2 cycles with in_valid = 1.
  - Require out_valid = 0, out_data = 0x00 and occupancy = 0 after the reset edges.
  - No accepted beat surfaces afterwards.
- Streaming:
  - Drive 0x01..0x10 back-to-back with out_ready = 1.
  - First out_valid appears 3 cycles after 0x01 is presented.
  - Output sequence is 0x01..0x10 with no gaps; in_ready stays 1 throughout.
- Backpressure:
  - With out_ready = 0, present 4 beats.
  - 3 are accepted, occupancy = 3, and in_ready = 0 on the 4th.
  - Raise out_ready: the 4th is accepted in that same cycle, occupancy stays 3, and the output order is preserved.
- Bubble collapse:
  - Send 0xA0, idle one cycle, then send 0xA1, with out_ready = 0.
  - Both are packed into the last two stages with occupancy = 2.
  - Release out_ready: 0xA0 and 0xA1 emerge on consecutive cycles.
- Flush:
  - Fill to occupancy 3, then pulse flush for 1 cycle with in_valid = 1.
  - in_ready = 0 during the flush cycle.
  - occupancy = 0 and out_valid = 0 next cycle; no flushed data ever appears.
  - A beat presented on the cycle after flush emerges after 3 cycles.
- Randomised ready/valid over 2000 cycles, run for DEPTH ∈ {1, 2, 5}:
  - A scoreboard shows output equals input order.
  - occupancy always equals accepted minus emitted minus flushed.
